// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the state type of the SRAM-backed slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdWait,
        StRdDone,
        StWr,
        StWrWait,
        StErr1,
        StErr2
    } slave_state_e;

endpackage

// File: rtl/ahb_lane_decode.sv
// Little-endian byte-lane decode: HSIZE and low address bits to active-low SRAM
// byte enables, flagging misaligned or unsupported sizes.
module ahb_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] ben_o,
    output logic       bad_o
);

    always_comb begin
        ben_o = 4'hF;
        bad_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: ben_o = ~(4'b0001 << addr_lo_i);
            HSIZE_HALF: begin
                bad_o = addr_lo_i[0];
                ben_o = addr_lo_i[1] ? 4'b0011 : 4'b1100;
            end
            HSIZE_WORD: begin
                bad_o = (addr_lo_i != 2'b00);
                ben_o = 4'b0000;
            end
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave serving byte/half/word transfers from a single-port synchronous
// SRAM with active-low enables, programmable wait states and two-cycle ERROR.
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned AW          = $clog2(DEPTH),
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [3:0]    sram_ben,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_din,
    input  logic [31:0]   sram_dout
);

    localparam logic [31:0] SPAN    = 32'(4 * DEPTH);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slave_state_e  state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    ben_q, ben_d;

    logic [31:0] offset;
    logic [3:0]  lane_ben;
    logic        lane_bad;
    logic        req_err;
    logic        active;
    logic        may_accept;
    logic        accept;

    ahb_lane_decode u_lane_decode (
        .size_i    (HSIZE),
        .addr_lo_i (HADDR[1:0]),
        .ben_o     (lane_ben),
        .bad_o     (lane_bad)
    );

    // Unsigned wrap makes addresses below BASE_ADDR land out of range.
    assign offset  = HADDR - BASE_ADDR;
    assign req_err = lane_bad | (offset >= SPAN);
    assign active  = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        ben_d      = ben_q;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        HRDATA     = 32'h0;
        sram_cen   = 1'b1;
        sram_wen   = 1'b1;
        sram_ben   = 4'hF;
        sram_din   = 32'h0;
        may_accept = 1'b0;

        unique case (state_q)
            StIdle: may_accept = 1'b1;
            StRdIssue: begin
                HREADYOUT = 1'b0;
                sram_cen  = 1'b0;
                cnt_d     = WS_LOAD;
                state_d   = (WAIT_STATES > 0) ? StRdWait : StRdDone;
            end
            StRdWait: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 4'd0) state_d = StRdDone;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StRdDone: begin
                HRDATA     = sram_dout;
                may_accept = 1'b1;
            end
            StWr: begin
                sram_cen = 1'b0;
                sram_wen = 1'b0;
                sram_ben = ben_q;
                sram_din = HWDATA;
                if (WAIT_STATES == 0) begin
                    may_accept = 1'b1;
                end else begin
                    HREADYOUT = 1'b0;
                    cnt_d     = WS_LOAD;
                    state_d   = StWrWait;
                end
            end
            StWrWait: begin
                if (cnt_q == 4'd0) begin
                    may_accept = 1'b1;
                end else begin
                    HREADYOUT = 1'b0;
                    cnt_d     = cnt_q - 4'd1;
                end
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = StErr2;
            end
            StErr2: begin
                HRESP      = HRESP_ERROR;
                may_accept = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Every state that lets a new address phase in ends its data phase here.
        accept = may_accept & HSEL & HREADY & active;
        if (may_accept) begin
            state_d = StIdle;
            if (accept) begin
                if (req_err) begin
                    state_d = StErr1;
                end else begin
                    addr_d  = offset[AW+1:2];
                    ben_d   = lane_ben;
                    state_d = HWRITE ? StWr : StRdIssue;
                end
            end
        end

        sram_addr = addr_q;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            ben_q   <= 4'hF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ben_q   <= ben_d;
        end
    end

endmodule
